matrix_result_drain: RTL and testbench

MATRIX_RESULT_DRAIN -- requirements
Module: matrix_result_drain

---
 rtl/matrix_pkg.sv | 19 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/matrix_result_drain.sv | 125 ++++++++++++
 tb/tb_matrix_result_drain.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix result drain.
// The optional checksum word is built only with MATRIX_DRAIN_CHECKSUM_EN defined.
package matrix_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_REARM = 2'd3
  } drain_state_t;

  // max(1, clog2(n)): a 1x1 matrix still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding drained result words; pointers wrap modulo DEPTH.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matrix_result_drain.sv
// Sweeps an N x N multiplier result row-major and streams it out valid/ready.
// Optional trailing checksum word with MATRIX_DRAIN_CHECKSUM_EN defined.
module matrix_result_drain
  import matrix_pkg::*;
#(
  parameter int N          = 10,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W = idx_width(N),
  localparam int CW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              z_stb,
  input  logic [DATA_W-1:0] z_out,
  output logic [IDX_W-1:0]  z_i,
  output logic [IDX_W-1:0]  z_j,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
  // m_data/m_last hold while m_valid && !m_ready.

  drain_state_t state, state_nxt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_push, fifo_pop, drained;
  logic [DATA_W:0] fifo_in, fifo_q;
  logic            in_flight, in_flight_last, issue, at_last;

  assign at_last = (z_i == IDX_W'(N - 1)) && (z_j == IDX_W'(N - 1));
  // Reserve a slot for every outstanding read so a capture can never overflow.
  assign issue = (state == ST_READ) &&
                 (({1'b0, fifo_count} + {{CW{1'b0}}, in_flight}) < (CW + 1)'(FIFO_DEPTH));

`ifdef MATRIX_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              sum_pending, push_sum;

  assign push_sum  = sum_pending && !in_flight && (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_push = in_flight || push_sum;
  assign fifo_in   = in_flight ? {1'b0, z_out} : {1'b1, sum};
  assign drained   = fifo_empty && !in_flight && !sum_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum         <= '0;
      sum_pending <= 1'b0;
    end else begin
      if (state == ST_IDLE && z_stb) sum <= '0;
      else if (in_flight)            sum <= sum + z_out;
      if (in_flight && in_flight_last) sum_pending <= 1'b1;
      else if (push_sum)               sum_pending <= 1'b0;
    end
  end
`else
  assign fifo_push = in_flight;
  assign fifo_in   = {in_flight_last, z_out};
  assign drained   = fifo_empty && !in_flight;
`endif

  assign fifo_pop = m_valid && m_ready;

  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_q),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid   = !fifo_empty;
  assign m_data    = m_valid ? fifo_q[DATA_W-1:0] : '0;
  assign m_last    = m_valid && fifo_q[DATA_W];
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (z_stb) state_nxt = ST_READ;
      ST_READ:  if (issue && at_last) state_nxt = ST_FLUSH;
      ST_FLUSH: if (drained) begin
        state_nxt = ST_REARM;
        done      = 1'b1;
      end
      ST_REARM: if (!z_stb) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_i            <= '0;
      z_j            <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue && at_last;
      if (issue) begin
        if (z_j == IDX_W'(N - 1)) begin
          z_j <= '0;
          z_i <= (z_i == IDX_W'(N - 1)) ? '0 : z_i + IDX_W'(1);
        end else begin
          z_j <= z_j + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Bench for matrix_result_drain: N=2 and N=3 instances sharing clock, reset and m_ready.
// Checksum expectations follow MATRIX_DRAIN_CHECKSUM_EN when it is defined.
module tb_matrix_result_drain;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_ready = 1'b1;

  logic z_stb2 = 1'b0, z_stb3 = 1'b0;
  logic [31:0] z_out2 = '0, z_out3 = '0;
  logic [0:0]  z_i2, z_j2;
  logic [1:0]  z_i3, z_j3;
  logic [31:0] m_data2, m_data3;
  logic m_valid2, m_valid3, m_last2, m_last3, busy2, busy3, done2, done3;
  logic [1:0] st2, st3;

  logic [31:0] mat2 [4];
  logic [31:0] mat3 [9];
  logic [32:0] exp_q2 [$];
  logic [32:0] exp_q3 [$];

  int tests = 0, fails = 0;
  int done_cnt2 = 0, done_cnt3 = 0, popped2 = 0, popped3 = 0, extra2 = 0, extra3 = 0;
  bit stall2 = 0, stall3 = 0;
  logic [32:0] stall_word2, stall_word3;

  always #5 clk = ~clk;

  matrix_result_drain #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .z_stb(z_stb2), .z_out(z_out2), .z_i(z_i2), .z_j(z_j2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2),
    .busy(busy2), .done(done2), .state_dbg(st2));

  matrix_result_drain #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .z_stb(z_stb3), .z_out(z_out3), .z_i(z_i3), .z_j(z_j3),
    .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready), .m_last(m_last3),
    .busy(busy3), .done(done3), .state_dbg(st3));

  // Multiplier model: one-cycle read latency from the issued address.
  always @(posedge clk) begin
    z_out2 <= mat2[int'(z_i2) * 2 + int'(z_j2)];
    z_out3 <= mat3[int'(z_i3) * 3 + int'(z_j3)];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon2();
    if (!rst) begin stall2 = 0; return; end
    if (done2) done_cnt2++;
    if (stall2) begin
      check("stall2_valid", 64'(m_valid2), 64'd1);
      check("stall2_word", 64'({m_last2, m_data2}), 64'(stall_word2));
    end
    if (m_valid2 && m_ready) begin
      popped2++;
      if (exp_q2.size() > 0) check("word2", 64'({m_last2, m_data2}), 64'(exp_q2.pop_front()));
      else extra2++;
      stall2 = 0;
    end else begin
      stall2 = m_valid2;
      stall_word2 = {m_last2, m_data2};
    end
  endtask

  task automatic mon3();
    if (!rst) begin stall3 = 0; return; end
    if (done3) done_cnt3++;
    if (stall3) begin
      check("stall3_valid", 64'(m_valid3), 64'd1);
      check("stall3_word", 64'({m_last3, m_data3}), 64'(stall_word3));
    end
    if (m_valid3 && m_ready) begin
      popped3++;
      if (exp_q3.size() > 0) check("word3", 64'({m_last3, m_data3}), 64'(exp_q3.pop_front()));
      else extra3++;
      stall3 = 0;
    end else begin
      stall3 = m_valid3;
      stall_word3 = {m_last3, m_data3};
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon2();
    mon3();
  end

  task automatic fill_random(input int which);
    if (which == 2) foreach (mat2[k]) mat2[k] = $urandom;
    else            foreach (mat3[k]) mat3[k] = $urandom;
  endtask

  // Expected stream: row-major words, then the checksum word when enabled.
  task automatic push_expect(input int which);
    logic [31:0] w, sum;
    logic last;
    sum = '0;
    for (int k = 0; k < which * which; k++) begin
      w = (which == 2) ? mat2[k] : mat3[k];
      sum = sum + w;
      last = (k == which * which - 1);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
      last = 1'b0;
`endif
      if (which == 2) exp_q2.push_back({last, w});
      else            exp_q3.push_back({last, w});
    end
`ifdef MATRIX_DRAIN_CHECKSUM_EN
    if (which == 2) exp_q2.push_back({1'b1, sum});
    else            exp_q3.push_back({1'b1, sum});
`endif
  endtask

  task automatic start_sweep(input int which);
    push_expect(which);
    if (which == 2) z_stb2 = 1'b1;
    else            z_stb3 = 1'b1;
  endtask

  // mode 0: m_ready high, 1: toggled every cycle, 2: random.
  task automatic wait_done(input int which, input int mode, input int budget, input string tag);
    int start;
    bit seen;
    start = (which == 2) ? done_cnt2 : done_cnt3;
    seen = 0;
    for (int cyc = 0; cyc < budget && !seen; cyc++) begin
      if (mode == 1)      m_ready = ~m_ready;
      else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
      else                m_ready = 1'b1;
      tick(1);
      seen = (((which == 2) ? done_cnt2 : done_cnt3) > start);
    end
    m_ready = 1'b1;
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic end_sweep(input int which);
    if (which == 2) z_stb2 = 1'b0;
    else            z_stb3 = 1'b0;
    tick(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, pos;
    foreach (mat2[k]) mat2[k] = '0;
    foreach (mat3[k]) mat3[k] = '0;

    // Reset state
    #1;
    check("rst_valid2", 64'(m_valid2), 0);
    check("rst_data2", 64'(m_data2), 0);
    check("rst_last2", 64'(m_last2), 0);
    check("rst_busy2", 64'(busy2), 0);
    check("rst_done2", 64'(done2), 0);
    check("rst_zi3", 64'(z_i3), 0);
    check("rst_zj3", 64'(z_j3), 0);
    check("rst_state3", 64'(st3), 64'(ST_IDLE));
    tick(2);
    rst = 1'b1;
    tick(2);

    // N=2 directed pattern 10*i+j, always ready
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) mat2[i * 2 + j] = 32'(10 * i + j);
    d0 = done_cnt2;
    start_sweep(2);
    wait_done(2, 0, 100, "done_n2");
    end_sweep(2);
    check("done_once_n2", 64'(done_cnt2 - d0), 1);
    check("busy_idle_n2", 64'(busy2), 0);
    check("q2_drained", 64'(exp_q2.size()), 0);

    // N=3 stalled downstream: only FIFO_DEPTH reads issue
    fill_random(3);
    m_ready = 1'b0;
    start_sweep(3);
    tick(20);
    pos = int'(z_i3) * 3 + int'(z_j3);
    check("stall_reads_n3", 64'(pos), 4);
    check("stall_valid_n3", 64'(m_valid3), 1);
    check("stall_head_n3", 64'(m_data3), 64'(mat3[0]));
    wait_done(3, 0, 200, "done_stall_n3");
    end_sweep(3);
    check("q3_drained_stall", 64'(exp_q3.size()), 0);

    // N=2 with m_ready toggling every cycle
    fill_random(2);
    p0 = popped2;
    start_sweep(2);
    wait_done(2, 1, 200, "done_toggle_n2");
    end_sweep(2);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
    check("toggle_count_n2", 64'(popped2 - p0), 5);
`else
    check("toggle_count_n2", 64'(popped2 - p0), 4);
`endif

    // z_stb held high after done: no restart until it drops
    fill_random(2);
    d0 = done_cnt2;
    start_sweep(2);
    wait_done(2, 0, 100, "done_hold_n2");
    p0 = popped2;
    tick(20);
    check("hold_no_words", 64'(popped2 - p0), 0);
    check("hold_no_done", 64'(done_cnt2 - d0), 1);
    check("hold_rearm", 64'(st2), 64'(ST_REARM));
    check("hold_busy", 64'(busy2), 1);
    z_stb2 = 1'b0;
    tick(1);
    fill_random(2);
    start_sweep(2);
    wait_done(2, 0, 100, "done_second_n2");
    end_sweep(2);
    check("second_done_n2", 64'(done_cnt2 - d0), 2);

    // Reset mid-sweep after 3 words
    fill_random(3);
    p0 = popped3;
    start_sweep(3);
    for (int cyc = 0; cyc < 100 && popped3 - p0 < 3; cyc++) tick(1);
    check("mid_words_n3", 64'(popped3 - p0), 3);
    #2;
    rst = 1'b0;
    z_stb3 = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid3), 0);
    check("mid_rst_data", 64'(m_data3), 0);
    check("mid_rst_last", 64'(m_last3), 0);
    check("mid_rst_busy", 64'(busy3), 0);
    check("mid_rst_done", 64'(done3), 0);
    check("mid_rst_zi", 64'(z_i3), 0);
    check("mid_rst_zj", 64'(z_j3), 0);
    exp_q3.delete();
    tick(2);
    rst = 1'b1;
    tick(3);
    check("post_rst_idle", 64'(st3), 64'(ST_IDLE));
    check("post_rst_valid", 64'(m_valid3), 0);
    fill_random(3);
    p0 = popped3;
    start_sweep(3);
    wait_done(3, 0, 200, "done_after_rst_n3");
    end_sweep(3);
`ifdef MATRIX_DRAIN_CHECKSUM_EN
    check("after_rst_count", 64'(popped3 - p0), 10);
`else
    check("after_rst_count", 64'(popped3 - p0), 9);
`endif

`ifdef MATRIX_DRAIN_CHECKSUM_EN
    // Checksum wraps modulo 2^32
    mat2[0] = 32'hFFFF_FFFF;
    mat2[1] = 32'd1;
    mat2[2] = 32'd2;
    mat2[3] = 32'd3;
    start_sweep(2);
    wait_done(2, 0, 100, "done_cksum_n2");
    end_sweep(2);
`endif

    // Randomized sweeps with random backpressure
    for (int r = 0; r < 4; r++) begin
      fill_random(3);
      start_sweep(3);
      wait_done(3, 2, 400, "done_rand_n3");
      end_sweep(3);
      fill_random(2);
      start_sweep(2);
      wait_done(2, 2, 200, "done_rand_n2");
      end_sweep(2);
    end

    check("final_q2", 64'(exp_q2.size()), 0);
    check("final_q3", 64'(exp_q3.size()), 0);
    check("extra2", 64'(extra2), 0);
    check("extra3", 64'(extra3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
